pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable, arbitrating between the following conditions:
- memory waits
- EX-stage redirects
- load-use hazards
- fetch waits
- halt draining
It also keeps a saturating stall-cycle counter for performance analysis.

Parameters:
CNT_W, 32, width of stall_count
REGW, 5, register-index width

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch for current PC complete this cycle
dhit  in  1  data access for MEM-stage instruction complete this cycle
mem_dREN  in  1  MEM-stage (EX/MEM output) load
mem_dWEN  in  1  MEM-stage store
ex_redirect  in  1  EX-stage (ID/EX output) taken branch, jump or jr; PC loads target
ex_dREN  in  1  EX-stage instruction is a load
ex_wsel  in  REGW  EX-stage destination register
id_rs  in  REGW  ID-stage (IF/ID output) source register rs
id_rt  in  REGW  ID-stage source register rt
id_uses_rt  in  1  ID-stage instruction reads rt
id_halt  in  1  ID-stage instruction is halt
wb_halt  in  1  halt bit at MEM/WB output
pc_en  out  1  PC update enable
ifid_en / ifid_flush  out  1 / 1  IF/ID latch controls
idex_en / idex_flush  out  1 / 1  ID/EX latch controls (drive decode_en / flush)
exmem_en / exmem_flush  out  1 / 1  EX/MEM latch controls
memwb_en / memwb_flush  out  1 / 1  MEM/WB latch controls
halt  out  1  processor halted, sticky
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
Clock and reset:
- One clock, CLK.
- Reset is asynchronous and active-low on nRST.
- Reset values: state=RUN, halt=0, stall_count=0.

Output timing:
- All latch and pc controls are combinational from state and inputs, so there is zero-cycle latency.
- A latch flush has priority over its enable inside the latch. The controller never asserts en and flush together on one latch.

Condition terms:
- mem_wait = (mem_dREN|mem_dWEN) & ~dhit
- load_use = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt))
- fetch_wait = ~ihit

Priority in RUN/DRAIN (first match wins):
1. mem_wait: pc_en=0, ifid_en=idex_en=exmem_en=0, memwb_flush=1 (bubble into WB, no duplicate writeback).
2. ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1, exmem_en=1, memwb_en=1.
   - Applies regardless of ihit; any outstanding fetch is discarded.
3. load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1.
4. fetch_wait: pc_en=0, ifid_flush=1, idex_en=exmem_en=memwb_en=1.
5. none: pc_en=1 and all *_en=1, all flushes 0.

State machine:
- RUN -> DRAIN when id_halt & idex_en & ~idex_flush, i.e. the halt advances into ID/EX.
  - A halt killed by redirect does not cause the transition.
- DRAIN: same priority table, except pc_en=0 always and ifid_flush=1 whenever ifid_en would be 1. No new instructions enter.
- DRAIN -> HALTED when wb_halt=1.
- HALTED:
  - halt=1; pc_en=0; all en and flush outputs 0; the pipeline is frozen.
  - stall_count is frozen.
  - Exit only via nRST.
- wb_halt in RUN (not reachable legally) forces HALTED directly.

stall_count:
- Increments by 1 on each RUN/DRAIN cycle where mem_wait|load_use|fetch_wait is true and ex_redirect did not win priority.
- Saturates at all-ones and never wraps.

Reset mid-operation: nRST low returns state to RUN and clears halt and the counter immediately, with no dependence on CLK.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - typedef enum logic [1:0] {RUN, DRAIN, HALTED} pctrl_state_t
  - typedef logic [REGW-1:0] regbits_t
  - a CNT_W-wide all-ones constant for saturation
- One combinational sub-module, hazard_unit, computes mem_wait, load_use and fetch_wait, with the rt-use qualification and the $zero exclusion.
- The FSM, priority encoder and counter stay in pipeline_ctrl.

Test Plan:
1. Load-use: ex_dREN=1, ex_wsel=8, id_rs=8, ihit=dhit=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, stall_count 0->1. With ex_wsel=0, no stall.
2. Mem wait over redirect: mem_dREN=1, dhit=0 for 3 cycles with ex_redirect=1 -> pc/ifid/idex/exmem en=0 and memwb_flush=1 for 3 cycles, stall_count=3. The 4th cycle (dhit=1) shows redirect flushes ifid and idex.
3. Redirect with ihit=0 -> pc_en=1, ifid_flush=1, idex_flush=1; stall_count unchanged.
4. Halt sequence: id_halt with normal advance -> DRAIN (pc_en=0 next cycle). wb_halt three cycles later -> halt=1 with all enables 0, held for 10 cycles.
5. Halt killed: id_halt=1 and ex_redirect=1 in the same cycle -> state stays RUN, pc_en=1.
6. Saturation/reset: preload with CNT_W=4 and fetch_wait held for 20 cycles -> stall_count sticks at 15. nRST pulse mid-DRAIN -> state RUN, halt=0, count=0 asynchronously.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

   localparam int REGW_DEF  = 5;
   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} pctrl_state_t;

   typedef logic [REGW_DEF-1:0] regbits_t;

   // Saturation ceiling for the default-width stall counter.
   localparam logic [CNT_W_DEF-1:0] CNT_ALL_ONES = '1;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: memory wait, load-use and fetch wait terms.
module hazard_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REGW = 5
) (
   input  logic            ihit,
   input  logic            dhit,
   input  logic            mem_dREN,
   input  logic            mem_dWEN,
   input  logic            ex_dREN,
   input  logic [REGW-1:0] ex_wsel,
   input  logic [REGW-1:0] id_rs,
   input  logic [REGW-1:0] id_rt,
   input  logic            id_uses_rt,
   output logic            mem_wait,
   output logic            load_use,
   output logic            fetch_wait
);

   logic wsel_live;
   logic rs_match;
   logic rt_match;

   // A load targeting $zero never produces a real dependency; rt only counts
   // when the decoding instruction actually reads it.
   always_comb begin
      wsel_live  = (ex_wsel != '0);
      rs_match   = (ex_wsel == id_rs);
      rt_match   = id_uses_rt & (ex_wsel == id_rt);
      mem_wait   = (mem_dREN | mem_dWEN) & ~dhit;
      load_use   = ex_dREN & wsel_live & (rs_match | rt_match);
      fetch_wait = ~ihit;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard arbitration, halt sequencing and stall-cycle counting for the 5-stage pipeline.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int REGW  = 5
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             ex_redirect,
   input  logic             ex_dREN,
   input  logic [REGW-1:0]  ex_wsel,
   input  logic [REGW-1:0]  id_rs,
   input  logic [REGW-1:0]  id_rt,
   input  logic             id_uses_rt,
   input  logic             id_halt,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             memwb_en,
   output logic             memwb_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   pctrl_state_t state, state_nxt;
   logic         mem_wait, load_use, fetch_wait;
   logic         stall_ev;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   hazard_unit #(.REGW(REGW)) u_hazard (
      .ihit       (ihit),
      .dhit       (dhit),
      .mem_dREN   (mem_dREN),
      .mem_dWEN   (mem_dWEN),
      .ex_dREN    (ex_dREN),
      .ex_wsel    (ex_wsel),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .mem_wait   (mem_wait),
      .load_use   (load_use),
      .fetch_wait (fetch_wait)
   );

   // Controller state register; halt is a pure decode of the HALTED state.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= RUN;
      else       state <= state_nxt;
   end

   // Priority encoder for latch/PC controls plus next-state selection.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
      memwb_flush = 1'b0;
      state_nxt   = state;

      if (state != HALTED) begin
         if (mem_wait) begin
            // Bubble into WB so the stalled MEM result is not written twice.
            memwb_flush = 1'b1;
         end else if (ex_redirect) begin
            // Wrong-path IF and ID instructions die; an outstanding fetch is dropped.
            pc_en      = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else if (load_use) begin
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else if (fetch_wait) begin
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
         end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end

         // While draining, nothing new may be fetched or decoded.
         if (state == DRAIN) begin
            pc_en = 1'b0;
            if (ifid_en) begin
               ifid_en    = 1'b0;
               ifid_flush = 1'b1;
            end
         end
      end

      unique case (state)
         RUN: begin
            if (wb_halt)                                state_nxt = HALTED;
            else if (id_halt & idex_en & ~idex_flush)   state_nxt = DRAIN;
         end
         DRAIN:   if (wb_halt) state_nxt = HALTED;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   assign halt = (state == HALTED);

   // A stall cycle is any hazard cycle that a winning redirect did not absorb.
   assign stall_ev = (state != HALTED) &
                     (mem_wait | ((load_use | fetch_wait) & ~ex_redirect));

   // Saturating performance counter of stall cycles.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)         stall_count <= '0;
      else if (stall_ev) stall_count <= sat_inc(stall_count);
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl with a table-driven reference model.
module tb_pipeline_ctrl;

   localparam int CNT_W = 4;
   localparam int REGW  = 5;

   logic CLK, nRST;
   logic ihit, dhit, mem_dREN, mem_dWEN, ex_redirect, ex_dREN;
   logic [REGW-1:0] ex_wsel, id_rs, id_rt;
   logic id_uses_rt, id_halt, wb_halt;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
   logic [CNT_W-1:0] stall_count;
   logic [8:0] ctl;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: 0 = running, 1 = draining, 2 = halted
   int m_state = 0;
   int m_cnt   = 0;

   pipeline_ctrl #(.CNT_W(CNT_W), .REGW(REGW)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_redirect(ex_redirect),
      .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_halt(id_halt), .wb_halt(wb_halt),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
      .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
      .halt(halt), .stall_count(stall_count)
   );

   // {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl}
   assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                 exmem_en, exmem_flush, memwb_en, memwb_flush};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Which row of the priority table applies: 1 mem wait, 2 redirect,
   // 3 load-use, 4 fetch wait, 5 free-running.
   function automatic int winner();
      bit mw, lu;
      mw = (mem_dREN || mem_dWEN) && !dhit;
      lu = ex_dREN && (ex_wsel != 0) &&
           ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
      if (mw)           return 1;
      if (ex_redirect)  return 2;
      if (lu)           return 3;
      if (!ihit)        return 4;
      return 5;
   endfunction

   function automatic logic [8:0] exp_ctl();
      logic [8:0] r;
      if (m_state == 2) return 9'b0;
      case (winner())
         1:       r = 9'b0_00_00_00_01;
         2:       r = 9'b1_01_01_10_10;
         3:       r = 9'b0_00_01_10_10;
         4:       r = 9'b0_01_10_10_10;
         default: r = 9'b1_10_10_10_10;
      endcase
      if (m_state == 1) begin
         r[8] = 1'b0;
         if (r[7]) r[7:6] = 2'b01;
      end
      return r;
   endfunction

   function automatic void model_advance();
      int w;
      logic [8:0] e;
      w = winner();
      e = exp_ctl();
      if (m_state != 2 && (w == 1 || w == 3 || w == 4))
         m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
      if (m_state == 0) begin
         if (wb_halt)                  m_state = 2;
         else if (id_halt && e[5] && !e[4]) m_state = 1;
      end else if (m_state == 1) begin
         if (wb_halt) m_state = 2;
      end
   endfunction

   task automatic set_idle();
      ihit = 1; dhit = 1; mem_dREN = 0; mem_dWEN = 0; ex_redirect = 0;
      ex_dREN = 0; ex_wsel = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
      id_halt = 0; wb_halt = 0;
   endtask

   task automatic tick();
      model_advance();
      @(negedge CLK);
   endtask

   task automatic apply_reset();
      set_idle();
      nRST = 1'b0;
      #1;
      m_state = 0;
      m_cnt   = 0;
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      nRST = 1'b1;
      #1 nRST = 1'b0;
      #1;
      n_checks++;
      if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %b want 0", halt); end
      n_checks++;
      if (stall_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", stall_count); end
      n_checks++;
      if (ctl !== 9'b1_10_10_10_10) begin n_fail++; $display("FAIL reset_ctl got %b want 110101010", ctl); end
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      m_state = 0; m_cnt = 0;
   endtask

   task automatic test_load_use();
      apply_reset();
      ex_dREN = 1; ex_wsel = 8; id_rs = 8;
      #1;
      n_checks++;
      if (ctl !== 9'b0_00_01_10_10) begin n_fail++; $display("FAIL loaduse_ctl got %b want 000011010", ctl); end
      tick();
      set_idle();
      #1;
      n_checks++;
      if (stall_count !== 4'd1) begin n_fail++; $display("FAIL loaduse_count got %0d want 1", stall_count); end
      ex_dREN = 1; ex_wsel = 0; id_rs = 0;
      #1;
      n_checks++;
      if (ctl !== 9'b1_10_10_10_10) begin n_fail++; $display("FAIL loaduse_zero got %b want 110101010", ctl); end
      tick();
      ex_dREN = 1; ex_wsel = 9; id_rs = 3; id_rt = 9; id_uses_rt = 0;
      #1;
      n_checks++;
      if (ctl !== 9'b1_10_10_10_10) begin n_fail++; $display("FAIL loaduse_rt_unused got %b want 110101010", ctl); end
      id_uses_rt = 1;
      #1;
      n_checks++;
      if (ctl !== 9'b0_00_01_10_10) begin n_fail++; $display("FAIL loaduse_rt_used got %b want 000011010", ctl); end
      tick();
      set_idle();
      #1;
      n_checks++;
      if (stall_count !== 4'd2) begin n_fail++; $display("FAIL loaduse_count2 got %0d want 2", stall_count); end
   endtask

   task automatic test_mem_wait_redirect();
      apply_reset();
      mem_dREN = 1; dhit = 0; ex_redirect = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (ctl !== 9'b0_00_00_00_01) begin n_fail++; $display("FAIL memwait_ctl[%0d] got %b want 000000001", i, ctl); end
         tick();
      end
      dhit = 1;
      #1;
      n_checks++;
      if (stall_count !== 4'd3) begin n_fail++; $display("FAIL memwait_count got %0d want 3", stall_count); end
      n_checks++;
      if (ctl !== 9'b1_01_01_10_10) begin n_fail++; $display("FAIL memwait_redirect got %b want 101011010", ctl); end
      tick();
      set_idle();
      #1;
      n_checks++;
      if (stall_count !== 4'd3) begin n_fail++; $display("FAIL memwait_count_after got %0d want 3", stall_count); end
   endtask

   task automatic test_redirect_no_ihit();
      apply_reset();
      ihit = 0; ex_redirect = 1;
      #1;
      n_checks++;
      if (ctl !== 9'b1_01_01_10_10) begin n_fail++; $display("FAIL redir_ihit_ctl got %b want 101011010", ctl); end
      tick();
      set_idle();
      #1;
      n_checks++;
      if (stall_count !== 4'd0) begin n_fail++; $display("FAIL redir_ihit_count got %0d want 0", stall_count); end
   endtask

   task automatic test_halt_sequence();
      apply_reset();
      id_halt = 1;
      tick();
      id_halt = 0;
      #1;
      n_checks++;
      if (ctl !== 9'b0_01_10_10_10) begin n_fail++; $display("FAIL halt_drain_ctl got %b want 001101010", ctl); end
      tick();
      tick();
      wb_halt = 1;
      #1;
      n_checks++;
      if (halt !== 1'b0) begin n_fail++; $display("FAIL halt_early got %b want 0", halt); end
      tick();
      wb_halt = 0;
      for (int i = 0; i < 10; i++) begin
         ihit = $urandom_range(0, 1); dhit = $urandom_range(0, 1);
         mem_dREN = $urandom_range(0, 1); ex_redirect = $urandom_range(0, 1);
         #1;
         n_checks++;
         if (halt !== 1'b1 || ctl !== 9'b0) begin
            n_fail++; $display("FAIL halted[%0d] halt=%b ctl=%b want halt=1 ctl=0", i, halt, ctl);
         end
         n_checks++;
         if (stall_count !== 4'd0) begin n_fail++; $display("FAIL halted_count[%0d] got %0d want 0", i, stall_count); end
         tick();
      end
   endtask

   task automatic test_halt_killed();
      apply_reset();
      id_halt = 1; ex_redirect = 1;
      tick();
      set_idle();
      #1;
      n_checks++;
      if (pc_en !== 1'b1 || ctl !== 9'b1_10_10_10_10) begin
         n_fail++; $display("FAIL halt_killed ctl got %b want 110101010", ctl);
      end
   endtask

   task automatic test_saturation_reset();
      apply_reset();
      ihit = 0;
      for (int i = 0; i < 20; i++) tick();
      #1;
      n_checks++;
      if (stall_count !== 4'd15) begin n_fail++; $display("FAIL sat_count got %0d want 15", stall_count); end
      ihit = 1; id_halt = 1;
      tick();
      id_halt = 0;
      #1;
      n_checks++;
      if (pc_en !== 1'b0) begin n_fail++; $display("FAIL sat_drain_pc got %b want 0", pc_en); end
      #2 nRST = 1'b0;
      #1;
      m_state = 0; m_cnt = 0;
      n_checks++;
      if (stall_count !== 4'd0 || halt !== 1'b0) begin
         n_fail++; $display("FAIL async_reset count=%0d halt=%b want 0/0", stall_count, halt);
      end
      n_checks++;
      if (ctl !== 9'b1_10_10_10_10) begin n_fail++; $display("FAIL async_reset_ctl got %b want 110101010", ctl); end
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         ihit        = ($urandom_range(0, 3) != 0);
         dhit        = ($urandom_range(0, 2) != 0);
         mem_dREN    = ($urandom_range(0, 3) == 0);
         mem_dWEN    = ($urandom_range(0, 5) == 0);
         ex_redirect = ($urandom_range(0, 4) == 0);
         ex_dREN     = ($urandom_range(0, 2) == 0);
         ex_wsel     = REGW'($urandom_range(0, 3));
         id_rs       = REGW'($urandom_range(0, 3));
         id_rt       = REGW'($urandom_range(0, 3));
         id_uses_rt  = $urandom_range(0, 1);
         id_halt     = ($urandom_range(0, 24) == 0);
         wb_halt     = (m_state == 1) ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 79) == 0);
         #1;
         n_checks++;
         if (ctl !== exp_ctl()) begin n_fail++; $display("FAIL rand_ctl[%0d] got %b want %b", i, ctl, exp_ctl()); end
         n_checks++;
         if (halt !== (m_state == 2)) begin n_fail++; $display("FAIL rand_halt[%0d] got %b want %0d", i, halt, m_state == 2); end
         n_checks++;
         if (stall_count !== CNT_W'(m_cnt)) begin
            n_fail++; $display("FAIL rand_count[%0d] got %0d want %0d", i, stall_count, m_cnt);
         end
         tick();
         if (m_state == 2 && $urandom_range(0, 4) == 0) apply_reset();
      end
   endtask

   initial begin
      set_idle();
      test_reset();
      test_load_use();
      test_mem_wait_redirect();
      test_redirect_no_ihit();
      test_halt_sequence();
      test_halt_killed();
      test_saturation_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
